// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - byte-addressed RAM answering a MOV/MOC four-phase memory handshake
//
// Purpose: captures a request from the control unit when MOV is seen in IDLE,
// waits WAIT_CYCLES extra cycles, then performs a big-endian byte, halfword or
// word access. MOC is held until MOV is withdrawn.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   clr      - synchronous active-high reset (RAM contents are kept)
//   MOV      - memory operation valid (level, held until MOC seen)
//   R_W      - 1 = read, 0 = write, sampled at capture
//   Address  - byte address from MAR, sampled at capture
//   DataIn   - write data from MDR, sampled at capture (right-justified)
//   Size     - 00 byte, 01 halfword, 10 word, 11 reserved (faults)
//   DataOut  - registered read data, zero-extended
//   MOC      - registered memory operation complete
//   ERR      - access fault, meaningful only while MOC = 1
`timescale 1ns/1ps
module memory_responder #(
   parameter int unsigned MEM_BYTES   = 256,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        MOV,
   input  logic        R_W,
   input  logic [31:0] Address,
   input  logic [31:0] DataIn,
   input  logic [1:0]  Size,
   output logic [31:0] DataOut,
   output logic        MOC,
   output logic        ERR
);

   localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic        rw_q,    rw_d;
   logic [31:0] addr_q,  addr_d;
   logic [31:0] din_q,   din_d;
   logic [1:0]  size_q,  size_d;
   logic [31:0] dout_q,  dout_d;
   logic        moc_q,   moc_d;
   logic        err_q,   err_d;

   logic [7:0]  mem_q [MEM_BYTES];

   logic [2:0]    nbytes;
   logic [32:0]   last_byte;
   logic          fault;
   logic          access_fire;
   logic [AW-1:0] a0, a1, a2, a3;
   logic [31:0]   rdata;

   // Access decode works only on captured request fields.
   always_comb begin
      nbytes = 3'd4;
      case (size_q)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
      // 33-bit sum so an address near 2^32 cannot wrap back into range.
      last_byte = {1'b0, addr_q} + 33'(nbytes) - 33'd1;
      fault = (size_q == 2'b11)
           || ((size_q == 2'b01) && addr_q[0])
           || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
           || (last_byte >= 33'(MEM_BYTES));

      a0 = addr_q[AW-1:0];
      a1 = a0 + AW'(1);
      a2 = a0 + AW'(2);
      a3 = a0 + AW'(3);

      rdata = 32'd0;
      case (size_q)
         2'b00:   rdata = {24'd0, mem_q[a0]};
         2'b01:   rdata = {16'd0, mem_q[a0], mem_q[a1]};
         default: rdata = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};
      endcase
   end

   // Abort (MOV low in BUSY) takes precedence over the access.
   assign access_fire = (state_q == S_BUSY) && MOV && (cnt_q == 4'd0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      din_d   = din_q;
      size_d  = size_q;
      dout_d  = dout_q;
      moc_d   = moc_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (MOV) begin
               rw_d    = R_W;
               addr_d  = Address;
               din_d   = DataIn;
               size_d  = Size;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (!MOV) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               moc_d   = 1'b1;
               err_d   = fault;
               if (rw_q) begin
                  dout_d = fault ? 32'd0 : rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            if (!MOV) begin
               moc_d   = 1'b0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rw_q    <= 1'b0;
         addr_q  <= 32'd0;
         din_q   <= 32'd0;
         size_q  <= 2'b00;
         dout_q  <= 32'd0;
         moc_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         size_q  <= size_d;
         dout_q  <= dout_d;
         moc_q   <= moc_d;
         err_q   <= err_d;
      end
   end

   // RAM is never cleared; clr only blocks a write landing on the same edge.
   always_ff @(posedge clk) begin
      if (!clr && access_fire && !rw_q && !fault) begin
         case (size_q)
            2'b00: begin
               mem_q[a0] <= din_q[7:0];
            end
            2'b01: begin
               mem_q[a0] <= din_q[15:8];
               mem_q[a1] <= din_q[7:0];
            end
            2'b10: begin
               mem_q[a0] <= din_q[31:24];
               mem_q[a1] <= din_q[23:16];
               mem_q[a2] <= din_q[15:8];
               mem_q[a3] <= din_q[7:0];
            end
            default: ;
         endcase
      end
   end

   assign DataOut = dout_q;
   assign MOC     = moc_q;
   assign ERR     = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - randomized self-checking bench for memory_responder
`timescale 1ns/1ps
module tb_memory_responder;

   localparam int MEM   = 256;
   localparam int WAITC = 2;

   logic        clk = 1'b0;
   logic        clr;
   logic        MOV;
   logic        R_W;
   logic [31:0] Address;
   logic [31:0] DataIn;
   logic [1:0]  Size;
   logic [31:0] DataOut;
   logic        MOC;
   logic        ERR;

   int checks = 0;
   int errors = 0;

   byte unsigned ref_mem [MEM];
   logic [31:0]  ref_dout;

   always #5 clk = ~clk;

   memory_responder #(.MEM_BYTES(MEM), .WAIT_CYCLES(WAITC)) dut (
      .clk     (clk),
      .clr     (clr),
      .MOV     (MOV),
      .R_W     (R_W),
      .Address (Address),
      .DataIn  (DataIn),
      .Size    (Size),
      .DataOut (DataOut),
      .MOC     (MOC),
      .ERR     (ERR)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: applies the request to the byte array and returns the expected DataOut/ERR.
   task automatic model(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size, output logic [31:0] exp_d, output logic exp_e);
      int     n;
      longint last;
      logic [31:0] v;
      n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      last = longint'(addr) + n - 1;
      exp_e = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
              (size == 2'b10 && addr % 4 != 0) || (last >= MEM);
      if (rw) begin
         if (exp_e) ref_dout = 32'd0;
         else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[addr + i]);
            ref_dout = v;
         end
      end else if (!exp_e) begin
         for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'(data >> (8 * (n - 1 - i)));
      end
      exp_d = ref_dout;
   endtask

   task automatic txn(input string tag, input logic rw, input logic [31:0] addr,
                      input logic [31:0] data, input logic [1:0] size, input int hold);
      logic [31:0] ed;
      logic        ee;
      int          n;
      model(rw, addr, data, size, ed, ee);
      MOV = 1'b1; R_W = rw; Address = addr; DataIn = data; Size = size;
      @(posedge clk); #1;
      n = 1;
      // Request fields must be ignored once captured.
      R_W = 1'($urandom); Address = $urandom; DataIn = $urandom; Size = 2'($urandom);
      while (MOC !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'(WAITC + 2));
      check({tag, " data"}, DataOut, ed);
      check({tag, " err"}, 32'(ERR), 32'(ee));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({tag, " hold moc"}, 32'(MOC), 32'd1);
      end
      MOV = 1'b0;
      @(posedge clk); #1;
      check({tag, " release moc"}, 32'(MOC), 32'd0);
      check({tag, " release err"}, 32'(ERR), 32'd0);
      check({tag, " release data"}, DataOut, ed);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d;
      logic [1:0]  s;
      logic        rw;
      clr = 1'b1; MOV = 1'b1; R_W = 1'b0; Address = 32'h10; DataIn = 32'h0; Size = 2'b10;
      ref_dout = 32'd0;
      for (int e = 0; e < 2; e++) begin
         @(posedge clk); #1;
         check("reset moc", 32'(MOC), 32'd0);
         check("reset err", 32'(ERR), 32'd0);
         check("reset data", DataOut, 32'd0);
      end
      clr = 1'b0;

      txn("wr 0x10", 1'b0, 32'h10, 32'h11223344, 2'b10, 0);
      // Fill the remaining RAM so every later read has a known value.
      for (int w = 0; w < MEM; w += 4)
         if (w != 32'h10) txn("fill", 1'b0, 32'(w), (w == 32'h20) ? 32'd0 : $urandom, 2'b10, 0);
      txn("rd w 0x10", 1'b1, 32'h10, 32'h0, 2'b10, 0);
      check("rd w 0x10 const", DataOut, 32'h11223344);
      txn("rd b 0x12", 1'b1, 32'h12, 32'h0, 2'b00, 0);
      check("rd b 0x12 const", DataOut, 32'h00000033);
      txn("rd h 0x10", 1'b1, 32'h10, 32'h0, 2'b01, 0);
      check("rd h 0x10 const", DataOut, 32'h00001122);

      txn("wr b 0x21", 1'b0, 32'h21, 32'h000000AB, 2'b00, 0);
      txn("wr h 0x22", 1'b0, 32'h22, 32'h0000CDEF, 2'b01, 0);
      txn("rd w 0x20", 1'b1, 32'h20, 32'h0, 2'b10, 0);
      check("rd w 0x20 const", DataOut, 32'h00ABCDEF);

      txn("fault rd w 0x13", 1'b1, 32'h13, 32'h0, 2'b10, 0);
      check("fault rd const", DataOut, 32'h0);
      txn("fault wr h 0x11", 1'b0, 32'h11, 32'hFFFF, 2'b01, 0);
      txn("fault size11", 1'b0, 32'h10, 32'hFFFFFFFF, 2'b11, 0);
      txn("fault w MEM-2", 1'b1, 32'(MEM - 2), 32'h0, 2'b10, 0);
      txn("fault w MEM", 1'b0, 32'(MEM), 32'hDEADBEEF, 2'b10, 0);
      txn("fault b MEM", 1'b1, 32'(MEM), 32'h0, 2'b00, 0);
      txn("fault w high", 1'b1, 32'hFFFFFFFC, 32'h0, 2'b10, 0);
      txn("after fault rd", 1'b1, 32'h10, 32'h0, 2'b10, 0);
      check("after fault const", DataOut, 32'h11223344);

      // Abort in BUSY: drop MOV one cycle after capture.
      MOV = 1'b1; R_W = 1'b0; Address = 32'h30; DataIn = 32'hCAFEF00D; Size = 2'b10;
      @(posedge clk); #1;
      @(posedge clk); #1;
      MOV = 1'b0;
      for (int e = 0; e < 4; e++) begin
         @(posedge clk); #1;
         check("abort moc", 32'(MOC), 32'd0);
      end
      txn("abort readback", 1'b1, 32'h30, 32'h0, 2'b10, 0);

      txn("hold 5", 1'b1, 32'h20, 32'h0, 2'b10, 5);

      // Reset while BUSY.
      MOV = 1'b1; R_W = 1'b0; Address = 32'h40; DataIn = 32'h12345678; Size = 2'b10;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      check("midreset moc", 32'(MOC), 32'd0);
      check("midreset data", DataOut, 32'd0);
      ref_dout = 32'd0;
      clr = 1'b0; MOV = 1'b0;
      @(posedge clk); #1;
      txn("midreset readback", 1'b1, 32'h40, 32'h0, 2'b10, 0);

      // Reset on the very edge that would perform the write.
      MOV = 1'b1; R_W = 1'b0; Address = 32'h50; DataIn = 32'h87654321; Size = 2'b10;
      @(posedge clk); #1;
      repeat (WAITC) begin
         @(posedge clk); #1;
      end
      clr = 1'b1;
      @(posedge clk); #1;
      check("edge reset moc", 32'(MOC), 32'd0);
      ref_dout = 32'd0;
      clr = 1'b0; MOV = 1'b0;
      @(posedge clk); #1;
      txn("edge reset readback", 1'b1, 32'h50, 32'h0, 2'b10, 0);

      for (int t = 0; t < 300; t++) begin
         rw = 1'($urandom);
         s  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         a  = 32'($urandom_range(0, MEM + 7));
         if ($urandom_range(0, 3) != 0) begin
            if (s == 2'b01) a[0] = 1'b0;
            if (s == 2'b10) a[1:0] = 2'b00;
         end
         d = $urandom;
         txn("random", rw, a, d, s, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
# memory_responder

Byte-addressed RAM that serves the control unit's memory handshake. The control unit initiates with MOV and R_W, and this block completes with MOC. It sits between MAR/MDR and the datapath bus. It captures the request, waits a programmable number of cycles, then performs a big-endian byte, halfword or word read or write. It holds MOC until the initiator withdraws MOV (four-phase handshake).

## Interface
- MEM_BYTES, 256: RAM size in bytes; power of two.
- WAIT_CYCLES, 2: extra wait cycles between request capture and access; 0..15.
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-high reset.
- MOV  input  1  memory operation valid from the control unit; level, held until MOC seen.
- R_W  input  1  1 = read, 0 = write; sampled at capture.
- Address  input  32  byte address, driven from MAR; sampled at capture.
- DataIn  input  32  write data, driven from MDR; sampled at capture; byte in [7:0], halfword in [15:0].
- Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved; sampled at capture.
- DataOut  output  32  read data, registered; zero-extended for byte and halfword.
- MOC  output  1  memory operation complete, registered.
- ERR  output  1  access fault, valid only while MOC = 1.

## Operation
- States:
  - IDLE: MOC = 0. MOV = 1 sampled at an edge captures R_W, Address, DataIn and Size, loads the counter with WAIT_CYCLES and goes to BUSY.
  - BUSY: counter decrements each edge. While the counter is 0, the next edge performs the access, sets MOC = 1, updates DataOut and ERR, and goes to DONE.
  - DONE: MOC, DataOut and ERR are held. MOV = 0 sampled at an edge clears MOC and ERR and goes to IDLE. DataOut keeps its last value.
- Layout is big-endian; A is the captured address:
  - Halfword = {mem[A], mem[A+1]}.
  - Word = {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
- Writes:
  - Byte writes mem[A] from DataIn[7:0].
  - Halfword writes mem[A] from DataIn[15:8] and mem[A+1] from DataIn[7:0].
  - Word writes mem[A..A+3] from DataIn[31:24], [23:16], [15:8] and [7:0] in that order.
- Faults set ERR = 1 with MOC = 1, suppress any write, and force DataOut = 0 on reads:
  - Size = 11.
  - Halfword with A[0] = 1.
  - Word with A[1:0] != 00.
  - Any addressed byte at or above MEM_BYTES.
- On a write, DataOut is unchanged.
- Abort: MOV = 0 sampled in BUSY returns the block to IDLE. No access is performed, MOC is never asserted, and memory is unchanged.
- Changes on R_W, Address, DataIn or Size after capture are ignored.

## Timing
- Reset: clr = 1 at an edge forces IDLE, MOC = 0, ERR = 0, DataOut = 0 and counter = 0, and discards any pending write. RAM contents are not cleared. clr has priority over every other input.
- Latency: if capture happens at edge k, MOC rises at edge k + WAIT_CYCLES + 1.
  - WAIT_CYCLES = 0 gives MOC at edge k + 1.
  - Read data is valid on DataOut in the same cycle MOC rises.
- Release: MOV is sampled low at edge m in DONE. MOC falls at edge m. The earliest next capture is edge m + 1, so there is always at least one cycle with MOC = 0 between transactions.
- MOV held high in DONE keeps MOC = 1 indefinitely, with no repeat access.
- Write data becomes visible to a subsequent read in the next transaction.
- clr and a completing access at the same edge: reset wins and memory is unchanged.

## Test plan
- Reset: drive clr = 1 for 2 edges with MOV = 1 -> MOC = 0, ERR = 0, DataOut = 0 throughout. After clr = 0, capture occurs at the first edge.
- Word write then reads (WAIT_CYCLES = 2):
  - Write word 0x11223344 to address 0x10 -> MOC rises 3 edges after capture.
  - Read word at 0x10 -> DataOut = 0x11223344.
  - Read byte at 0x12 -> DataOut = 0x00000033.
  - Read halfword at 0x10 -> DataOut = 0x00001122.
- Byte/halfword writes:
  - Write byte 0xAB to 0x21 and halfword 0xCDEF to 0x22 into a word pre-written with 0.
  - Read word at 0x20 -> DataOut = 0x00ABCDEF.
- Faults, each returning MOC with ERR = 1 and memory unchanged:
  - Word read at 0x13 -> DataOut = 0.
  - Halfword write at 0x11.
  - Size = 11.
  - Word at MEM_BYTES - 2.
  - ERR falls with MOC.
- Handshake edges:
  - Drop MOV in BUSY during a word write to 0x30 -> no MOC; a later read of 0x30 shows the old value.
  - Hold MOV 5 extra cycles in DONE -> MOC stays 1; released one edge after MOV falls.
  - Issue back-to-back requests -> one MOC = 0 cycle between them.
- Reset mid-operation: assert clr in BUSY during a write -> IDLE, MOC = 0, and the target location is unchanged on readback.
